// File: rtl/vram_cpu_arbiter.sv
// CPU-to-VRAM write scheduler: synchronised strobe capture, small write FIFO,
// and a slot FSM that issues writes while SLOT_X[2:0] is 6..7.
module vram_cpu_arbiter #(
  parameter int          DEPTH    = 4,
  parameter logic [7:0]  ATTR_RST = 8'h07
) (
  input  logic        CLK_25,
  input  logic        RST,
  input  logic [13:0] CPU_A,
  input  logic [7:0]  CPU_D,
  input  logic        CPU_nWR,
  input  logic [3:0]  SLOT_X,
  output logic        WR_EN,
  output logic [13:0] WR_ADDR,
  output logic [7:0]  WR_DATA,
  output logic        CPU_nWAIT,
  output logic [3:0]  LEVEL,
  output logic        OVERFLOW
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] FULL_L  = 4'(DEPTH);
  localparam logic [3:0] NWAIT_L = 4'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, ATTR} state_t;

  state_t        state, state_n;
  logic [2:0]    nwr_sync;            // [1] is the synchronised strobe, [2] its previous value
  logic          push, push_ok, pop, full, empty;
  logic [21:0]   mem [DEPTH];
  logic [21:0]   head;
  logic [AW-1:0] wptr, rptr;
  logic [3:0]    level;
  logic          is_char, is_char_n;
  logic [7:0]    attr, attr_n;
  logic          wr_en_n;
  logic [13:0]   wr_addr_n;
  logic [7:0]    wr_data_n;
  logic          slot5, slot7;

  assign push      = nwr_sync[2] & ~nwr_sync[1];
  assign full      = (level == FULL_L);
  assign empty     = (level == 4'd0);
  assign push_ok   = push & (~full | pop);
  assign head      = mem[rptr];
  assign slot5     = (SLOT_X[2:0] == 3'd5);
  assign slot7     = (SLOT_X[2:0] == 3'd7);
  assign LEVEL     = level;
  assign CPU_nWAIT = (level < NWAIT_L);

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    wr_en_n   = WR_EN;
    wr_addr_n = WR_ADDR;
    wr_data_n = WR_DATA;
    is_char_n = is_char;
    attr_n    = attr;
    case (state)
      IDLE: if (slot5 && !empty) begin
        pop       = 1'b1;
        wr_en_n   = 1'b1;
        wr_addr_n = head[21:8];
        wr_data_n = head[7:0];
        is_char_n = (head[21:20] == 2'b00);
        if (head[21:20] == 2'b01) attr_n = head[7:0];
        state_n   = ISSUE;
      end
      ISSUE: if (slot7) begin
        wr_en_n = 1'b0;
        state_n = is_char ? ATTR : IDLE;
      end
      ATTR: if (slot5) begin
        // WR_ADDR still holds the char address, so its low bits select the cell
        wr_en_n   = 1'b1;
        wr_addr_n = {2'b01, WR_ADDR[11:0]};
        wr_data_n = attr;
        is_char_n = 1'b0;
        state_n   = ISSUE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK_25) begin
    if (RST) begin
      nwr_sync <= 3'b111;
      wptr     <= '0;
      rptr     <= '0;
      level    <= 4'd0;
      OVERFLOW <= 1'b0;
      state    <= IDLE;
      is_char  <= 1'b0;
      attr     <= ATTR_RST;
      WR_EN    <= 1'b0;
      WR_ADDR  <= 14'd0;
      WR_DATA  <= 8'd0;
    end else begin
      nwr_sync <= {nwr_sync[1:0], CPU_nWR};
      state    <= state_n;
      is_char  <= is_char_n;
      attr     <= attr_n;
      WR_EN    <= wr_en_n;
      WR_ADDR  <= wr_addr_n;
      WR_DATA  <= wr_data_n;
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (push_ok && !pop)      level <= level + 4'd1;
      else if (!push_ok && pop) level <= level - 4'd1;
      if (push && full && !pop) OVERFLOW <= 1'b1;
    end
  end

  always_ff @(posedge CLK_25) begin
    if (push_ok && !RST) mem[wptr] <= {CPU_A, CPU_D};
  end

endmodule
